// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Brief    : Shared state encoding, op encoding and beat-count helper for the
//            sequential matrix add/subtract unit.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int beats(input int elems, input int lanes);
        return (elems + lanes - 1) / lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_lane_alu.sv
`default_nettype none
// ============================================================================
// Module   : matrix_lane_alu
// Brief    : One element lane: unsigned add/subtract with carry/borrow flag.
//            MATRIX_SATURATE_EN clamps overflowing results instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_lane_alu
    import matrix_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              op,
    output logic [DATA_W-1:0] y,
    output logic              ovf
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // The extra MSB is the carry for add and the borrow for subtract
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        if (op == OP_SUB) begin
            ovf = w_diff[DATA_W];
            y   = w_diff[DATA_W-1:0];
`ifdef MATRIX_SATURATE_EN
            if (w_diff[DATA_W]) y = '0;
`endif
        end else begin
            ovf = w_sum[DATA_W];
            y   = w_sum[DATA_W-1:0];
`ifdef MATRIX_SATURATE_EN
            if (w_sum[DATA_W]) y = '1;
`endif
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : matrix_addsub_seq
// Brief    : Sequential DIM x DIM matrix add/subtract, LANES elements per beat,
//            sticky overflow. MATRIX_SATURATE_EN selects clamping lanes.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_addsub_seq
    import matrix_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIM    = 5,
    parameter int LANES  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      op,
    input  logic [DIM*DIM*DATA_W-1:0] matrix_a,
    input  logic [DIM*DIM*DATA_W-1:0] matrix_b,
    output logic                      busy,
    output logic                      done,
    output logic [DIM*DIM*DATA_W-1:0] result,
    output logic                      overflow
);

    localparam int ELEMS  = DIM * DIM;
    localparam int NBEATS = beats(ELEMS, LANES);
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int IDX_W  = $clog2(ELEMS + LANES) + 1;
    localparam int AW     = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_op;
    logic                r_ovf;
    logic [DATA_W-1:0]   r_a      [ELEMS];
    logic [DATA_W-1:0]   r_b      [ELEMS];
    logic [DATA_W-1:0]   r_result [ELEMS];

    logic [DATA_W-1:0]   w_a [LANES];
    logic [DATA_W-1:0]   w_b [LANES];
    logic [DATA_W-1:0]   w_y [LANES];
    logic [LANES-1:0]    w_ovf;
    logic [LANES-1:0]    w_lane_valid;
    logic [ELEMS-1:0]    w_elem_we;
    logic [DATA_W-1:0]   w_elem_val [ELEMS];
    logic                w_accept;
    logic                w_last_beat;
    logic                w_beat_ovf;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_last_beat = (r_beat == BEAT_W'(NBEATS - 1));
    // Lanes past the last element in a partial beat must not raise the flag
    assign w_beat_ovf  = |(w_ovf & w_lane_valid);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last_beat) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- lanes ----------------
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [IDX_W-1:0] w_idx;

            assign w_idx           = IDX_W'(r_beat) * IDX_W'(LANES) + IDX_W'(l);
            assign w_lane_valid[l] = (w_idx < IDX_W'(ELEMS));
            assign w_a[l]          = w_lane_valid[l] ? r_a[w_idx[AW-1:0]] : '0;
            assign w_b[l]          = w_lane_valid[l] ? r_b[w_idx[AW-1:0]] : '0;

            matrix_lane_alu #(
                .DATA_W (DATA_W)
            ) u_alu (
                .a   (w_a[l]),
                .b   (w_b[l]),
                .op  (r_op),
                .y   (w_y[l]),
                .ovf (w_ovf[l])
            );
        end

        // Each element has a fixed beat and lane, so its write enable is static
        for (genvar e = 0; e < ELEMS; e++) begin : g_elem
            localparam int BEAT = e / LANES;
            localparam int LANE = e % LANES;

            assign w_elem_we[e]  = (r_state == RUN) && (r_beat == BEAT_W'(BEAT));
            assign w_elem_val[e] = w_y[LANE];
            assign result[e*DATA_W +: DATA_W] = r_result[e];
        end
    endgenerate

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < ELEMS; e++) begin
                r_a[e]      <= '0;
                r_b[e]      <= '0;
                r_result[e] <= '0;
            end
            r_op   <= OP_ADD;
            r_beat <= '0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            for (int e = 0; e < ELEMS; e++) begin
                r_a[e] <= matrix_a[e*DATA_W +: DATA_W];
                r_b[e] <= matrix_b[e*DATA_W +: DATA_W];
            end
            r_op   <= op;
            r_beat <= '0;
            r_ovf  <= 1'b0;
        end else if (r_state == RUN) begin
            for (int e = 0; e < ELEMS; e++) begin
                if (w_elem_we[e]) r_result[e] <= w_elem_val[e];
            end
            r_beat <= r_beat + BEAT_W'(1);
            r_ovf  <= r_ovf | w_beat_ovf;
        end
    end

    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: doc/matrix_addsub_seq.md
Name: matrix_addsub_seq

Overview:
- Sequential, parametrised successor of the combinational 5x5 matrix adder.
- Adds or subtracts two DIM x DIM matrices of DATA_W-bit unsigned elements, LANES elements per clock.
- Latches operands on a start handshake and sets an overflow flag.
- Sits between the matrix operand register file and the result writeback logic of the matrix coprocessor.

Parameters:
- DATA_W, 8: element width in bits.
- DIM, 5: matrix dimension; matrix holds DIM*DIM elements.
- LANES, 5: elements processed per cycle; legal range 1..DIM*DIM.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; accepted only in IDLE.
- op  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with start.
- matrix_a  input  DIM*DIM*DATA_W  operand A; element i at [i*DATA_W +: DATA_W]; sampled with start.
- matrix_b  input  DIM*DIM*DATA_W  operand B; same packing as A.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse when the final beat is written.
- result  output  DIM*DIM*DATA_W  result matrix; same packing as A; held until the next accepted start.
- overflow  output  1  sticky: any element carried (add) or borrowed (sub) in the current operation.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, busy 0, done 0, overflow 0, result all zeros, beat index 0, operand registers 0. Reset has priority over everything. Reset mid-RUN aborts the operation with no done pulse.
- ELEMS = DIM*DIM. NBEATS = ceil(ELEMS/LANES).
- State IDLE:
  - start=1 at an edge: latch matrix_a, matrix_b and op. Clear overflow. Set index 0. Go to RUN.
  - result keeps its previous value until overwritten beat by beat.
- State RUN (busy=1):
  - Each edge computes elements index*LANES .. min(index*LANES+LANES, ELEMS)-1 from the latched operands and writes them into result.
  - overflow |= carry/borrow of each element in that beat.
  - The final beat is partial when ELEMS mod LANES != 0; lanes beyond ELEMS-1 are inert and never write or flag.
  - On the edge that writes beat NBEATS-1: go to DONE.
- State DONE: done=1, busy=0 for exactly one cycle. Next edge goes to IDLE.
- Latency: start accepted at edge k, done high in the cycle after edge k+NBEATS. Default config: NBEATS=5.
- start is ignored in RUN and DONE. No queuing. Input changes during RUN do not affect the result.
- Arithmetic: unsigned, DATA_W bits.
  - add: carry when A+B >= 2^DATA_W.
  - sub: borrow when A < B.
  - Default (no macro): wrap modulo 2^DATA_W.
- op is fixed for the whole operation; there is no per-element mode.

Optional Feature:
- Macro MATRIX_SATURATE_EN.
- Defined: on carry an element clamps to 2^DATA_W-1; on borrow it clamps to 0. overflow is still set.
- Undefined: wrap-around results; overflow behaviour is unchanged.
- The port list is identical in both builds.

Decomposition:
- Package matrix_pkg:
  - state enum IDLE/RUN/DONE.
  - op encoding constants OP_ADD=0, OP_SUB=1.
  - function beats(elems, lanes) returning the ceiling division.
- Sub-module matrix_lane_alu (parameter DATA_W):
  - Inputs a, b, op. Outputs y, ovf.
  - Handles add/sub, carry/borrow and the MATRIX_SATURATE_EN clamp.
  - Instantiated LANES times by a generate loop.
- The top level holds the FSM, beat counter, operand and result registers, and lane muxing.

Test Plan:
- Default params, op=0, all A=1, all B=2, one start -> busy for 5 cycles, done pulses once, every element=3, overflow=0.
- op=0, element 0: A=200, B=100 -> element 0 = 44 (wrap) or 255 (MATRIX_SATURATE_EN); overflow=1; all other elements correct.
- op=1, all A=5, B=7 -> every element = 254 (wrap) or 0 (saturate); overflow=1. Then a second op=1 with A=7, B=5 -> every element=2, overflow cleared to 0.
- DIM=5, LANES=4: A[i]=i, B[i]=1 -> NBEATS=7; done in the cycle after edge k+7; element 24=25; no write beyond element 24.
- start asserted during RUN with different operands -> ignored; result matches the first operands; only one done pulse.
- rst asserted in beat 2 of RUN -> next cycle busy=0, done=0, result=0, overflow=0; no done pulse follows; a subsequent start completes normally.
